pipe_hazard_unit: RTL

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit_if.sv | 43 ++++
 rtl/pipe_hazard_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit_if.sv
// Decode/hazard-unit bundle: decode slot, per-stage results and the forward/stall/kill/writeback responses.
// Purely combinational wiring; the hazard unit drives the slave-side outputs.
interface pipe_hazard_unit_if #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5,
    parameter int DEPTH  = 3
) ();
    logic                    id_valid;
    logic [RIDX_W-1:0]       id_rs1;
    logic [RIDX_W-1:0]       id_rs2;
    logic                    id_use_rs1;
    logic                    id_use_rs2;
    logic [RIDX_W-1:0]       id_rd;
    logic                    id_regwrite;
    logic                    id_is_load;
    logic                    br_taken;
    logic [DEPTH*XLEN-1:0]   stage_data;

    logic                    fwd1_en;
    logic [XLEN-1:0]         fwd1_data;
    logic                    fwd2_en;
    logic [XLEN-1:0]         fwd2_data;
    logic                    stall;
    logic                    kill;
    logic [DEPTH-1:0]        stage_valid;
    logic                    wb_en;
    logic [RIDX_W-1:0]       wb_rd;
    logic [15:0]             stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_is_load, br_taken, stage_data,
        input  fwd1_en, fwd1_data, fwd2_en, fwd2_data, stall, kill,
               stage_valid, wb_en, wb_rd, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_is_load, br_taken, stage_data,
        output fwd1_en, fwd1_data, fwd2_en, fwd2_data, stall, kill,
               stage_valid, wb_en, wb_rd, stall_count
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// In-order pipeline hazard unit: operand forwarding, load-use stall, branch squash, WB tracking.
// Forward/stall/kill are combinational from tracked stage state; a stall inserts one bubble per cycle held.
module pipe_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int RIDX_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int BR_STAGE   = 0,
    parameter int FETCH_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_unit_if.slave hz
);
    localparam int KW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DEPTH-1:0]  rw_q,  rw_d;
    logic [DEPTH-1:0]  ld_q,  ld_d;
    logic [RIDX_W-1:0] rd_q [DEPTH];
    logic [RIDX_W-1:0] rd_d [DEPTH];
    logic [KW-1:0]     kcnt_q, kcnt_d;
    logic [15:0]       scnt_q, scnt_d;

    logic              m1, m2;
    logic              ok1, ok2;
    logic [XLEN-1:0]   d1, d2;
    logic              hz1, hz2;
    logic              br_fire;
    logic              kill_w;
    logic              stall_w;

    // Scan oldest to youngest so the lowest-index match overwrites older ones.
    always_comb begin
        m1  = 1'b0;
        m2  = 1'b0;
        ok1 = 1'b0;
        ok2 = 1'b0;
        d1  = '0;
        d2  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (vld_q[k] && rw_q[k] && (rd_q[k] == hz.id_rs1)) begin
                m1  = 1'b1;
                ok1 = !ld_q[k] || (k >= LOAD_STAGE);
                d1  = hz.stage_data[k*XLEN +: XLEN];
            end
            if (vld_q[k] && rw_q[k] && (rd_q[k] == hz.id_rs2)) begin
                m2  = 1'b1;
                ok2 = !ld_q[k] || (k >= LOAD_STAGE);
                d2  = hz.stage_data[k*XLEN +: XLEN];
            end
        end
        m1 = m1 && hz.id_use_rs1 && (hz.id_rs1 != '0);
        m2 = m2 && hz.id_use_rs2 && (hz.id_rs2 != '0);
        hz1 = m1 && !ok1;
        hz2 = m2 && !ok2;
    end

    always_comb begin
        br_fire = hz.br_taken && (kcnt_q == '0) && vld_q[BR_STAGE];
        kill_w  = br_fire || (kcnt_q != '0);
        stall_w = hz.id_valid && (hz1 || hz2) && !kill_w;

        if (br_fire) begin
            kcnt_d = KW'(FETCH_LAT - 1);
        end else if (kcnt_q != '0) begin
            kcnt_d = kcnt_q - 1'b1;
        end else begin
            kcnt_d = kcnt_q;
        end

        if (stall_w && (scnt_q != 16'hFFFF)) begin
            scnt_d = scnt_q + 16'd1;
        end else begin
            scnt_d = scnt_q;
        end
    end

    // Entries younger than the resolving branch land in stages 1..BR_STAGE after the shift.
    always_comb begin
        vld_d[0] = hz.id_valid && !stall_w && !kill_w;
        rw_d[0]  = hz.id_regwrite;
        ld_d[0]  = hz.id_is_load;
        rd_d[0]  = hz.id_rd;
        for (int k = 1; k < DEPTH; k++) begin
            vld_d[k] = vld_q[k-1] && !(br_fire && (k <= BR_STAGE));
            rw_d[k]  = rw_q[k-1];
            ld_d[k]  = ld_q[k-1];
            rd_d[k]  = rd_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            rw_q   <= '0;
            ld_q   <= '0;
            kcnt_q <= '0;
            scnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            rw_q   <= rw_d;
            ld_q   <= ld_d;
            kcnt_q <= kcnt_d;
            scnt_q <= scnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= rd_d[k];
            end
        end
    end

    assign hz.fwd1_en     = m1 && ok1;
    assign hz.fwd1_data   = (m1 && ok1) ? d1 : '0;
    assign hz.fwd2_en     = m2 && ok2;
    assign hz.fwd2_data   = (m2 && ok2) ? d2 : '0;
    assign hz.stall       = stall_w;
    assign hz.kill        = kill_w;
    assign hz.stage_valid = vld_q;
    assign hz.wb_en       = vld_q[DEPTH-1] && rw_q[DEPTH-1] && (rd_q[DEPTH-1] != '0);
    assign hz.wb_rd       = rd_q[DEPTH-1];
    assign hz.stall_count = scnt_q;
endmodule
